// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM_B two-master arbiter.
// Holds the FSM state encoding, the requester indices and the latency counter setup.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  // Wide enough for the largest supported read latency (3).
  localparam int CNT_W = 2;

  // The counter is loaded with RAM_LAT-1 so that the WAIT state lasts exactly RAM_LAT cycles.
  function automatic logic [CNT_W-1:0] lat_init(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/ram_arb_rr2.sv
// Combinational two-way round-robin pick.
// A lone request always wins; a tie goes to the requester indexed by prio.
module ram_arb_rr2
  import ram_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic sel,
  output logic any
);

  always_comb begin
    any = req0 | req1;
    if (req0 && req1) begin
      sel = prio;
    end else if (req1) begin
      sel = REQ_AUX;
    end else begin
      sel = REQ_CPU;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port RAM_B block RAM between the CPU port and a secondary master.
// The req/gnt/done handshake has a fixed latency: gnt at t+1, done at t+2+RAM_LAT.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          RSTN,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  localparam logic [CNT_W-1:0] CNT_INIT = lat_init(RAM_LAT);

  arb_state_t       state_reg;
  logic             prio_reg;
  logic             owner_reg;
  logic             is_read_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             gnt0_reg;
  logic             gnt1_reg;
  logic             done0_reg;
  logic             done1_reg;
  logic             busy_reg;
  logic             ram_we_reg;
  logic [AW-1:0]    ram_addr_reg;
  logic [DW-1:0]    ram_din_reg;
  logic [DW-1:0]    rdata_reg;

  logic             sel;
  logic             any;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  ram_arb_rr2 u_rr2 (
    .req0 (req0),
    .req1 (req1),
    .prio (prio_reg),
    .sel  (sel),
    .any  (any)
  );

  assign sel_we    = (sel == REQ_AUX) ? we1    : we0;
  assign sel_addr  = (sel == REQ_AUX) ? addr1  : addr0;
  assign sel_wdata = (sel == REQ_AUX) ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state_reg    <= IDLE;
      prio_reg     <= REQ_CPU;
      owner_reg    <= REQ_CPU;
      is_read_reg  <= 1'b0;
      cnt_reg      <= '0;
      gnt0_reg     <= 1'b0;
      gnt1_reg     <= 1'b0;
      done0_reg    <= 1'b0;
      done1_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      ram_we_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_din_reg  <= '0;
      rdata_reg    <= '0;
    end else begin
      gnt0_reg  <= 1'b0;
      gnt1_reg  <= 1'b0;
      done0_reg <= 1'b0;
      done1_reg <= 1'b0;
      case (state_reg)
        // DONE arbitrates exactly like IDLE so back-to-back grants lose no cycle.
        IDLE, DONE: begin
          if (any) begin
            state_reg    <= ACCESS;
            owner_reg    <= sel;
            is_read_reg  <= ~sel_we;
            ram_addr_reg <= sel_addr;
            ram_din_reg  <= sel_wdata;
            ram_we_reg   <= sel_we;
            gnt0_reg     <= (sel == REQ_CPU);
            gnt1_reg     <= (sel == REQ_AUX);
            busy_reg     <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        ACCESS: begin
          // RAM has sampled the command; drop the strobe so a write is one cycle wide.
          ram_we_reg <= 1'b0;
          prio_reg   <= ~owner_reg;
          cnt_reg    <= CNT_INIT;
          state_reg  <= WAIT;
          busy_reg   <= 1'b1;
        end
        WAIT: begin
          busy_reg <= 1'b1;
          if (cnt_reg == '0) begin
            if (is_read_reg) begin
              rdata_reg <= ram_dout;
            end
            done0_reg <= (owner_reg == REQ_CPU);
            done1_reg <= (owner_reg == REQ_AUX);
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
      endcase
    end
  end

  assign gnt0     = gnt0_reg;
  assign gnt1     = gnt1_reg;
  assign done0    = done0_reg;
  assign done1    = done1_reg;
  assign busy     = busy_reg;
  assign ram_we   = ram_we_reg;
  assign ram_addr = ram_addr_reg;
  assign ram_din  = ram_din_reg;
  assign rdata    = rdata_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a behavioural RAM_B model, a done-side scoreboard,
// and a second instance built with RAM_LAT=3 whose read data is driven directly.
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct packed {
    logic          owner;
    logic          is_read;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, ram_we, busy;
  logic [DW-1:0] rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addr;

  logic          req0_3, we0_3;
  logic [AW-1:0] addr0_3;
  logic [DW-1:0] wdata0_3, dout3;
  logic          gnt0_3, gnt1_3, done0_3, done1_3, ram_we_3, busy_3;
  logic [DW-1:0] rdata_3, ram_din_3;
  logic [AW-1:0] ram_addr_3;

  int            checks = 0;
  int            errors = 0;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_prio  = 1'b0;
  int            we_run    = 0;

  logic [DW-1:0] ram_mem [0:1023];
  logic [DW-1:0] ref_mem [0:1023];

  ram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(1)) dut (
    .clk(clk), .RSTN(rstn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  ram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(3)) dut3 (
    .clk(clk), .RSTN(rstn),
    .req0(req0_3), .we0(we0_3), .addr0(addr0_3), .wdata0(wdata0_3), .gnt0(gnt0_3), .done0(done0_3),
    .req1(1'b0), .we1(1'b0), .addr1('0), .wdata1('0), .gnt1(gnt1_3), .done1(done1_3),
    .rdata(rdata_3), .ram_addr(ram_addr_3), .ram_we(ram_we_3), .ram_din(ram_din_3),
    .ram_dout(dout3), .busy(busy_3)
  );

  // RAM_B model: read-first, one-cycle registered read.
  always @(posedge clk) begin
    ram_dout <= ram_mem[ram_addr];
    if (ram_we === 1'b1) ram_mem[ram_addr] = ram_din;
  end

  // Done-side scoreboard and write-strobe width monitor.
  always @(negedge clk) begin
    if (done0 === 1'b1 || done1 === 1'b1) begin
      checks++;
      if (done0 === 1'b1 && done1 === 1'b1) begin
        errors++;
        $display("FAIL done_both: done0=%b done1=%b, required a single done", done0, done1);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done0=%b done1=%b, required no done", done0, done1);
      end else begin
        mon_e = sb.pop_front();
        if (done1 !== mon_e.owner) begin
          errors++;
          $display("FAIL done_owner: done1=%b, required owner %0d", done1, mon_e.owner);
        end
        if (mon_e.is_read) exp_rdata = mon_e.data;
        checks++;
        if (rdata !== exp_rdata) begin
          errors++;
          $display("FAIL done_rdata: rdata=%h, required %h", rdata, exp_rdata);
        end
        $display("done owner=%0d read=%0b rdata=%h", done1, mon_e.is_read, rdata);
      end
    end
    if (ram_we === 1'b1) begin
      we_run++;
      checks++;
      if (we_run > 1) begin
        errors++;
        $display("FAIL ram_we_width: ram_we high %0d cycles, required 1", we_run);
      end
    end else begin
      we_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access on the LAT=1 instance, checking grant and done latency.
  task automatic do_access(input logic who, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    int   n;
    logic seen;
    exp_t e;
    if (who) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else     begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      tick(); n++;
      if (gnt0 === 1'b1 || gnt1 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 1 || gnt1 !== who || gnt0 !== !who) begin
      errors++;
      $display("FAIL gnt_latency: gnt0=%b gnt1=%b after %0d cycles, required gnt%0d after 1", gnt0, gnt1, n, who);
    end
    checks++;
    if (ram_we !== we || ram_addr !== a || (we && ram_din !== d) || busy !== 1'b1) begin
      errors++;
      $display("FAIL access_cmd: we=%b addr=%h din=%h busy=%b, required we=%b addr=%h din=%h busy=1",
               ram_we, ram_addr, ram_din, busy, we, a, d);
    end
    if (who) req1 = 1'b0; else req0 = 1'b0;
    e.owner = who; e.is_read = !we; e.data = we ? d : ref_mem[a];
    sb.push_back(e);
    if (we) ref_mem[a] = d;
    exp_prio = ~who;
    seen = 1'b0;
    while (!seen && n < 12) begin
      tick(); n++;
      if (done0 === 1'b1 || done1 === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || n != 3) begin
      errors++;
      $display("FAIL done_latency: done after %0d cycles (seen=%b), required 3", n, seen);
    end
  endtask

  task automatic test_reset();
    int   n;
    exp_t e;
    rstn = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3FF; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h3FF; wdata1 = '0;
    repeat (3) begin
      tick();
      checks++;
      if ({gnt0, gnt1, done0, done1, ram_we, busy} !== 6'b0 || ram_addr !== '0 ||
          ram_din !== '0 || rdata !== '0) begin
        errors++;
        $display("FAIL reset_state: gnt=%b%b done=%b%b we=%b busy=%b addr=%h din=%h rdata=%h, required all 0",
                 gnt0, gnt1, done0, done1, ram_we, busy, ram_addr, ram_din, rdata);
      end
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_gnt: gnt0=%b gnt1=%b, required gnt0=1 gnt1=0", gnt0, gnt1);
    end
    req0 = 1'b0; req1 = 1'b0;
    e.owner = 1'b0; e.is_read = 1'b1; e.data = ref_mem[10'h3FF];
    sb.push_back(e);
    exp_prio = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 8) begin tick(); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL reset_first_done: %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_write_read();
    do_access(1'b0, 1'b1, 10'h005, 32'hDEADBEEF);
    do_access(1'b0, 1'b0, 10'h005, '0);
  endtask

  task automatic test_contention();
    int   n, last, grants;
    logic exp_owner;
    exp_t e;
    do_access(1'b1, 1'b0, 10'h3FF, '0);
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'h3FF;
    exp_owner = exp_prio; grants = 0; last = -1; n = 0;
    while (grants < 4 && n < 40) begin
      tick(); n++;
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        checks++;
        if (gnt1 !== exp_owner || gnt0 !== !exp_owner || (last >= 0 && n - last != 3)) begin
          errors++;
          $display("FAIL contention_gnt: grant %0d gnt0=%b gnt1=%b spacing=%0d, required gnt%0d spacing 3",
                   grants, gnt0, gnt1, n - last, exp_owner);
        end
        e.owner = exp_owner; e.is_read = 1'b1;
        e.data = exp_owner ? ref_mem[10'h3FF] : ref_mem[10'h005];
        sb.push_back(e);
        last = n; grants++;
        if (grants == 4) begin req0 = 1'b0; req1 = 1'b0; end
        exp_owner = ~exp_owner;
      end
    end
    exp_prio = exp_owner;
    checks++;
    if (grants != 4) begin
      errors++;
      $display("FAIL contention_count: %0d grants, required 4", grants);
      req0 = 1'b0; req1 = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 10) begin tick(); n++; end
  endtask

  task automatic test_cancel();
    exp_t e;
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h005;
    tick();
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL cancel_gnt0: gnt0=%b, required 1", gnt0);
    end
    req0 = 1'b0;
    e.owner = 1'b0; e.is_read = 1'b1; e.data = ref_mem[10'h005];
    sb.push_back(e);
    exp_prio = 1'b1;
    tick();
    req1 = 1'b1; we1 = 1'b1; addr1 = 10'h3FF; wdata1 = 32'h0BADF00D;
    tick();
    req1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_we !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL cancel_quiet: gnt0=%b gnt1=%b ram_we=%b busy=%b, required all 0",
                 gnt0, gnt1, ram_we, busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3FF;
    tick();
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_gnt: gnt0=%b, required 1", gnt0);
    end
    rstn = 1'b0; req0 = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || ram_we !== 1'b0 || gnt0 !== 1'b0 || done0 !== 1'b0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%b we=%b gnt0=%b done0=%b rdata=%h, required all 0",
               busy, ram_we, gnt0, done0, rdata);
    end
    rstn = 1'b1;
    exp_rdata = '0;
    exp_prio = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_no_done: done0=%b, required 0", done0);
      end
    end
    do_access(1'b0, 1'b0, 10'h3FF, '0);
  endtask

  task automatic test_lat3();
    dout3 = 32'h11111111;
    req0_3 = 1'b1; we0_3 = 1'b0; addr0_3 = 10'h02A;
    tick();
    checks++;
    if (gnt0_3 !== 1'b1 || ram_addr_3 !== 10'h02A || ram_we_3 !== 1'b0) begin
      errors++;
      $display("FAIL lat3_gnt: gnt0=%b addr=%h we=%b, required 1 02a 0", gnt0_3, ram_addr_3, ram_we_3);
    end
    req0_3 = 1'b0;
    for (int n = 2; n <= 4; n++) begin
      tick();
      checks++;
      if (done0_3 !== 1'b0 || busy_3 !== 1'b1) begin
        errors++;
        $display("FAIL lat3_wait: cycle %0d done0=%b busy=%b, required done0=0 busy=1", n, done0_3, busy_3);
      end
      dout3 = (n == 4) ? 32'hCAFEF00D : 32'h22222222;
    end
    tick();
    checks++;
    if (done0_3 !== 1'b1 || rdata_3 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL lat3_done: done0=%b rdata=%h, required 1 cafef00d", done0_3, rdata_3);
    end
    $display("done lat3 owner=0 read=1 rdata=%h", rdata_3);
    dout3 = 32'hFFFF0000;
    tick();
    checks++;
    if (done0_3 !== 1'b0 || rdata_3 !== 32'hCAFEF00D || busy_3 !== 1'b0) begin
      errors++;
      $display("FAIL lat3_hold: done0=%b rdata=%h busy=%b, required 0 cafef00d 0", done0_3, rdata_3, busy_3);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    ram_mem[10'h3FF] = 32'h12345678;
    ref_mem[10'h3FF] = 32'h12345678;
    req0_3 = 1'b0; we0_3 = 1'b0; addr0_3 = '0; wdata0_3 = '0; dout3 = '0;
    test_reset();
    test_write_read();
    test_contention();
    test_cancel();
    test_reset_mid();
    test_lat3();
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port RAM_B block RAM (10-bit word address, 32-bit data, one-cycle synchronous read) between two requesters.
- Requester 0 is the CPU-side MIO_BUS RAM port. Requester 1 is a secondary master, such as a display-refresh or DMA scanner.
- Sits between those masters and RAM_B.
- Provides a req/gnt/done handshake, round-robin fairness and a fixed, deterministic access latency.

Parameters:
- AW, 10, RAM word-address width.
- DW, 32, RAM data width.
- RAM_LAT, 1, RAM read latency in cycles. Legal values are 1 to 3.

Ports:
- clk  in  1  system clock, shared with RAM_B clka.
- RSTN  in  1  reset, synchronous to clk, active-low.
- req0  in  1  requester 0 access request, level-held until gnt0.
- we0  in  1  requester 0 write enable: 1 = write, 0 = read.
- addr0  in  AW  requester 0 word address.
- wdata0  in  DW  requester 0 write data.
- gnt0  out  1  one-cycle pulse: requester 0 command accepted.
- done0  out  1  one-cycle pulse: requester 0 access complete; rdata valid for reads.
- req1, we1, addr1, wdata1, gnt1, done1: same as requester 0, for requester 1.
- rdata  out  DW  read data, valid in the done cycle, held until the next done.
- ram_addr  out  AW  to RAM_B addra.
- ram_we  out  1  to RAM_B wea.
- ram_din  out  DW  to RAM_B dina.
- ram_dout  in  DW  from RAM_B douta.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (RSTN=0 at a clk edge):
  - state=IDLE, prio=0.
  - gnt0, gnt1, done0, done1, ram_we, busy = 0.
  - ram_addr=0, ram_din=0, rdata=0.
  - Latency counter = 0.
- States are IDLE, ACCESS, WAIT and DONE. All outputs are registered.
- IDLE:
  - With no request pending, stay in IDLE.
  - If exactly one req is high, select it.
  - If both are high, select the requester indexed by prio.
  - On the edge that selects: capture the selected addr/wdata/we into ram_addr/ram_din/ram_we, pulse that requester's gnt, store owner, go to ACCESS.
- ACCESS (1 cycle):
  - RAM samples ram_addr/ram_we/ram_din at the end of this cycle.
  - Leaving ACCESS forces ram_we=0, so each write is exactly one cycle wide.
  - Set prio = ~owner.
  - Go to WAIT with the counter loaded to RAM_LAT-1.
- WAIT (RAM_LAT cycles):
  - Count down.
  - On the final cycle (counter==0), register rdata<=ram_dout if the access was a read. For writes, rdata is unchanged.
  - Pulse done[owner] and go to DONE.
- DONE (1 cycle):
  - Acts as IDLE: it may arbitrate a new request and issue a gnt on the same edge it exits.
  - With no request pending it goes to IDLE.
- Latency:
  - req high at cycle t in IDLE gives gnt at t+1, RAM sample at the end of t+1, and done at t+2+RAM_LAT (t+3 for the default).
  - Back-to-back throughput is one access per 2+RAM_LAT cycles.
- Handshake rules:
  - A requester keeps req/we/addr/wdata stable until it sees gnt.
  - It may change them, or drop req, from the gnt cycle onward.
  - Dropping req before gnt cancels the request with no side effects.
  - A req still high in the done cycle counts as a new request.
- Fairness:
  - prio toggles only after a completed grant.
  - A continuously requesting pair alternates 0,1,0,1.
  - A lone requester is granted repeatedly regardless of prio.
- Reset mid-operation:
  - The in-flight access is abandoned: no done, ram_we=0 from the reset edge.
  - A write already sampled by the RAM stays committed.
- Address/data widths pass straight through; there is no arithmetic or wrap.
- rdata stays valid after done until the next read completes.

Decomposition:
- Package ram_arb_pkg:
  - state encoding: IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, DONE=2'd3;
  - requester index constants: REQ_CPU=1'b0, REQ_AUX=1'b1.
- Sub-module ram_arb_rr2: purely combinational round-robin pick.
  - Inputs: req0, req1, prio.
  - Outputs: sel, any.
  - Instantiated once. The FSM, counter and capture registers stay in ram_arbiter.

Test Plan:
- Reset:
  - Hold RSTN=0 for 3 cycles with req0=req1=1 → all outputs 0, no gnt, no ram_we.
  - Release → gnt0 one cycle later (prio=0).
- Single write then read, requester 0:
  - Write addr0=10'h005, wdata0=32'hDEADBEEF, we0=1 → gnt0 at t+1, ram_we high exactly one cycle, done0 at t+3.
  - Then read addr 10'h005 → done0 with rdata=32'hDEADBEEF.
- Contention:
  - req0 and req1 both held high for 4 accesses → gnt order 0,1,0,1, grants spaced 3 cycles apart.
  - done1 reads return the contents of addr1=10'h3FF preloaded as 32'h12345678.
- Cancel:
  - req1 raised while requester 0 is in WAIT, then dropped before gnt1 → no gnt1, no ram_we, state returns to IDLE.
- Reset mid-access:
  - RSTN=0 in the ACCESS cycle of a read → no done0, busy=0 next cycle.
  - A subsequent read of the same address completes normally.
- RAM_LAT=3 build:
  - Single read → done at t+5.
  - rdata is captured from ram_dout in the last WAIT cycle; changing ram_dout afterwards does not alter rdata.
